// File: rtl/xadac_pkg.sv
// Shared definitions for the pipelined xadac vector multiply-accumulate unit.
// Carries the default vector/lane/element widths, the request mode encoding and
// the group-length clamp used when a request is accepted.
package xadac_pkg;

  localparam int unsigned VectorWidth = 128;
  localparam int unsigned SumWidth    = 32;
  localparam int unsigned ElemWidth   = 8;
  localparam int unsigned MaxGroup    = SumWidth / ElemWidth;
  localparam int unsigned NumLanes    = VectorWidth / SumWidth;

  // Bit order matches req_mode: [2] saturate, [1] vs2 signed, [0] vs1 signed.
  typedef struct packed {
    logic sat;
    logic s2;
    logic s1;
  } vmacc_mode_t;

  // Effective group length J = min(G, max_g).
  function automatic logic [4:0] clamp_group(input logic [4:0] g, input int unsigned max_g);
    clamp_group = (32'(g) > max_g) ? 5'(max_g) : g;
  endfunction

endpackage

// File: rtl/xadac_vmacc_pipe_if.sv
// Request/response bus of the xadac vmacc unit.
// master: issues req_* and resp_ready; slave: returns req_ready and resp_*.
//   req_valid/req_ready  request handshake
//   req_id               tag echoed on resp_id
//   req_imm              group length G
//   req_mode             [0] vs1 signed, [1] vs2 signed, [2] saturate
//   req_vs1/2/3          element operands and accumulator input
//   resp_valid/ready     response handshake
//   resp_vd / resp_rd    result vector / scalar result (always 0)
interface xadac_vmacc_pipe_if #(
  parameter int unsigned VectorWidth = xadac_pkg::VectorWidth,
  parameter int unsigned IdWidth     = 5
);

  logic                   req_valid;
  logic                   req_ready;
  logic [IdWidth-1:0]     req_id;
  logic [4:0]             req_imm;
  logic [2:0]             req_mode;
  logic [VectorWidth-1:0] req_vs1;
  logic [VectorWidth-1:0] req_vs2;
  logic [VectorWidth-1:0] req_vs3;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [IdWidth-1:0]     resp_id;
  logic [VectorWidth-1:0] resp_vd;
  logic [31:0]            resp_rd;

  modport master (
    output req_valid, req_id, req_imm, req_mode, req_vs1, req_vs2, req_vs3, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_vd, resp_rd
  );

  modport slave (
    input  req_valid, req_id, req_imm, req_mode, req_vs1, req_vs2, req_vs3, resp_ready,
    output req_ready, resp_valid, resp_id, resp_vd, resp_rd
  );

endinterface

// File: rtl/xadac_vmacc_lane.sv
// One SumWidth lane of the vmacc datapath, split into two independent
// combinational halves that sit on either side of the pipeline registers.
//   vs1, vs2, s1, s2, grp -> prod : masked, sign-extended element products
//   prod_reg, acc_in, sat -> sum  : accumulate with wrap or saturation
module xadac_vmacc_lane #(
  parameter int unsigned SumWidth  = 32,
  parameter int unsigned ElemWidth = 8
) (
  input  logic [SumWidth-1:0]                                vs1,
  input  logic [SumWidth-1:0]                                vs2,
  input  logic                                               s1,
  input  logic                                               s2,
  input  logic [4:0]                                         grp,
  output logic [(SumWidth/ElemWidth)*(2*ElemWidth+1)-1:0]    prod,
  input  logic [(SumWidth/ElemWidth)*(2*ElemWidth+1)-1:0]    prod_reg,
  input  logic [SumWidth-1:0]                                acc_in,
  input  logic                                               sat,
  output logic [SumWidth-1:0]                                sum
);

  localparam int unsigned Group     = SumWidth / ElemWidth;
  localparam int unsigned ProdWidth = 2 * ElemWidth + 1;
  localparam int unsigned AccWidth  = SumWidth + 8;

  always_comb begin
    logic signed [ElemWidth:0]     ea;
    logic signed [ElemWidth:0]     eb;
    logic signed [2*ElemWidth+1:0] p;
    prod = '0;
    for (int j = 0; j < Group; j++) begin
      ea = {s1 & vs1[j*ElemWidth+ElemWidth-1], vs1[j*ElemWidth +: ElemWidth]};
      eb = {s2 & vs2[j*ElemWidth+ElemWidth-1], vs2[j*ElemWidth +: ElemWidth]};
      p  = ea * eb;
      // Elements beyond the effective group length contribute nothing.
      if (j < int'(grp)) prod[j*ProdWidth +: ProdWidth] = p[ProdWidth-1:0];
    end
  end

  always_comb begin
    logic [AccWidth-1:0]   acc;
    logic [AccWidth-SumWidth:0] hi;
    acc = {{(AccWidth-SumWidth){acc_in[SumWidth-1]}}, acc_in};
    for (int j = 0; j < Group; j++) begin
      acc = acc + {{(AccWidth-ProdWidth){prod_reg[j*ProdWidth+ProdWidth-1]}},
                   prod_reg[j*ProdWidth +: ProdWidth]};
    end
    // The result fits SumWidth signed iff all bits above the lane sign agree with it.
    hi = acc[AccWidth-1:SumWidth-1];
    if (sat && !((&hi) || !(|hi))) begin
      sum = acc[AccWidth-1] ? {1'b1, {(SumWidth-1){1'b0}}} : {1'b0, {(SumWidth-1){1'b1}}};
    end else begin
      sum = acc[SumWidth-1:0];
    end
  end

endmodule

// File: rtl/xadac_vmacc_pipe.sv
// Pipelined vector multiply-accumulate unit (xadac slave side).
// Stage 0 captures the element products; middle stages delay; the last stage
// holds the lane sums. Each stage advances when empty or when its successor
// advances, so req_ready is a combinational function of resp_ready.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : xadac_vmacc_pipe_if slave (request in, response out)
module xadac_vmacc_pipe #(
  parameter int unsigned VectorWidth = xadac_pkg::VectorWidth,
  parameter int unsigned SumWidth    = xadac_pkg::SumWidth,
  parameter int unsigned ElemWidth   = xadac_pkg::ElemWidth,
  parameter int unsigned IdWidth     = 5,
  parameter int unsigned NumStages   = 2
) (
  input logic               clk,
  input logic               rstn,
  xadac_vmacc_pipe_if.slave bus
);

  import xadac_pkg::*;

  localparam int unsigned LaneCnt      = VectorWidth / SumWidth;
  localparam int unsigned GroupLen     = SumWidth / ElemWidth;
  localparam int unsigned LaneProdBits = GroupLen * (2 * ElemWidth + 1);
  localparam int unsigned ProdBits     = LaneCnt * LaneProdBits;
  // Stages carrying products; with a single stage that stage also feeds the output.
  localparam int unsigned DataStages   = (NumStages > 1) ? NumStages - 1 : 1;
  localparam int unsigned DLast        = DataStages - 1;
  localparam int unsigned Last         = NumStages - 1;

  vmacc_mode_t            req_mode;
  logic [4:0]             grp;
  logic [ProdBits-1:0]    prod_new;
  logic [VectorWidth-1:0] sum_vd;
  logic [NumStages-1:0]   vld_q;
  logic [NumStages-1:0]   adv;
  logic [IdWidth-1:0]     id_q   [NumStages];
  logic [DataStages-1:0]  sat_q;
  logic [VectorWidth-1:0] vs3_q  [DataStages];
  logic [ProdBits-1:0]    prod_q [DataStages];

  assign req_mode = vmacc_mode_t'(bus.req_mode);
  assign grp      = clamp_group(bus.req_imm, GroupLen);

  for (genvar l = 0; l < LaneCnt; l++) begin : g_lane
    xadac_vmacc_lane #(
      .SumWidth  (SumWidth),
      .ElemWidth (ElemWidth)
    ) u_lane (
      .vs1      (bus.req_vs1[l*SumWidth +: SumWidth]),
      .vs2      (bus.req_vs2[l*SumWidth +: SumWidth]),
      .s1       (req_mode.s1),
      .s2       (req_mode.s2),
      .grp      (grp),
      .prod     (prod_new[l*LaneProdBits +: LaneProdBits]),
      .prod_reg (prod_q[DLast][l*LaneProdBits +: LaneProdBits]),
      .acc_in   (vs3_q[DLast][l*SumWidth +: SumWidth]),
      .sat      (sat_q[DLast]),
      .sum      (sum_vd[l*SumWidth +: SumWidth])
    );
  end

  // A stage can advance if the output is being drained or any stage at or after it is empty.
  always_comb begin
    logic room;
    adv  = '0;
    room = bus.resp_ready;
    for (int k = int'(NumStages) - 1; k >= 0; k--) begin
      room   = room | !vld_q[k];
      adv[k] = room;
    end
  end

  assign bus.req_ready = adv[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      sat_q <= '0;
      for (int k = 0; k < NumStages; k++) id_q[k] <= '0;
      for (int k = 0; k < DataStages; k++) begin
        vs3_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      if (adv[0]) vld_q[0] <= bus.req_valid;
      for (int k = 1; k < NumStages; k++) begin
        if (adv[k]) vld_q[k] <= vld_q[k-1];
      end
      if (adv[0] && bus.req_valid) begin
        id_q[0]   <= bus.req_id;
        sat_q[0]  <= req_mode.sat;
        vs3_q[0]  <= bus.req_vs3;
        prod_q[0] <= prod_new;
      end
      for (int k = 1; k < NumStages; k++) begin
        if (adv[k] && vld_q[k-1]) id_q[k] <= id_q[k-1];
      end
      for (int k = 1; k < DataStages; k++) begin
        if (adv[k] && vld_q[k-1]) begin
          sat_q[k]  <= sat_q[k-1];
          vs3_q[k]  <= vs3_q[k-1];
          prod_q[k] <= prod_q[k-1];
        end
      end
    end
  end

  if (NumStages > 1) begin : g_sum_reg
    logic [VectorWidth-1:0] vd_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vd_q <= '0;
      end else if (adv[Last] && vld_q[Last-1]) begin
        vd_q <= sum_vd;
      end
    end
    assign bus.resp_vd = vd_q;
  end else begin : g_sum_comb
    assign bus.resp_vd = sum_vd;
  end

  assign bus.resp_valid = vld_q[Last];
  assign bus.resp_id    = id_q[Last];
  assign bus.resp_rd    = '0;

endmodule
